// File: rtl/ntt_pkg.sv
// Purpose: shared types and constants for the NTT stage controller.
// Contents: FSM state enum, twiddle-offset helper, pass/issue-count helpers.
// Used by: ntt_stage_ctrl.
package ntt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } state_e;

    // Start of the twiddle block for radix-4 pass s: 1 + 4 + ... + 4^(s-1).
    // Equals (4^s-1)/3. The loop has a fixed bound so it unrolls cleanly.
    function automatic int tw_offset(input int s);
        int off;
        off = 0;
        for (int i = 0; i < 8; i++) begin
            if (i < s) off = off * 4 + 1;
        end
        return off;
    endfunction

    // Number of passes: radix-4 passes plus one radix-2 pass for odd N_LOG.
    function automatic int nstg_f(input int n_log);
        return n_log / 2 + n_log % 2;
    endfunction

    // Issues per pass: N/4 butterflies, one per bank address.
    function automatic int ncyc_f(input int n_log);
        return 1 << (n_log - 2);
    endfunction

endpackage

// File: rtl/ntt_wb_delay.sv
// Purpose: DEPTH-stage shift register carrying {valid, addr} for write-back.
// Latency: exactly DEPTH cycles; shifts every cycle.
// Backpressure: none; the line never stalls, so output timing is fixed.
// Ports: clk_i, rst_ni (async active-low), vld_i/addr_i in, vld_o/addr_o out.
module ntt_wb_delay #(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 6
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              vld_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic              vld_o,
    output logic [ADDR_W-1:0] addr_o
);

    logic [DEPTH-1:0]             vld_q;
    logic [DEPTH-1:0][ADDR_W-1:0] addr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q  <= '0;
            addr_q <= '0;
        end else begin
            vld_q[0]  <= vld_i;
            addr_q[0] <= addr_i;
            for (int i = 1; i < DEPTH; i++) begin
                vld_q[i]  <= vld_q[i-1];
                addr_q[i] <= addr_q[i-1];
            end
        end
    end

    assign vld_o  = vld_q[DEPTH-1];
    assign addr_o = addr_q[DEPTH-1];

endmodule

// File: rtl/ntt_stage_ctrl.sv
// Purpose: pass sequencer and address generator feeding the compact butterfly.
// Latency: issue outputs follow state combinationally; write-back lags issue by BF_LAT.
// Backpressure: hold_i freezes issue in RUN; drain and write-back ignore it.
// Ports: clk_i, rst_ni (async active-low), start_i, hold_i; sel_o, ien_o,
//        rd_addr_o, tw_addr_o, stage_o, wb_en_o, wb_addr_o, busy_o, done_o.
// Option: NTT_STAGE_CTRL_PERF_EN adds perf_cycles_o / perf_stalls_o counters.
module ntt_stage_ctrl
    import ntt_pkg::*;
#(
    parameter int N_LOG  = 8,
    parameter int BF_LAT = 2,
    parameter int ADDR_W = N_LOG - 2,
    parameter int TW_W   = N_LOG
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              hold_i,
    output logic              sel_o,
    output logic              ien_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic [TW_W-1:0]   tw_addr_o,
    output logic [3:0]        stage_o,
    output logic              wb_en_o,
    output logic [ADDR_W-1:0] wb_addr_o,
    output logic              busy_o,
`ifdef NTT_STAGE_CTRL_PERF_EN
    output logic [15:0]       perf_cycles_o,
    output logic [15:0]       perf_stalls_o,
`endif
    output logic              done_o
);

    localparam int R4    = N_LOG / 2;
    localparam int DRN_W = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;

    localparam logic [ADDR_W-1:0] LAST_CNT = ADDR_W'(ncyc_f(N_LOG) - 1);
    localparam logic [DRN_W-1:0]  LAST_DRN = DRN_W'(BF_LAT - 1);
    localparam logic [3:0]        NSTG_4   = 4'(nstg_f(N_LOG));

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  cnt_q, cnt_d;
    logic [3:0]         stage_q, stage_d;
    logic [DRN_W-1:0]   drn_q, drn_d;
    logic               ien;
    logic               done;
    logic               busy;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            stage_q <= '0;
            drn_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stage_q <= stage_d;
            drn_q   <= drn_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stage_d = stage_q;
        drn_d   = drn_q;
        ien     = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    stage_d = '0;
                end
            end
            ST_RUN: begin
                if (!hold_i) begin
                    ien   = 1'b1;
                    cnt_d = cnt_q + ADDR_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        state_d = ST_DRAIN;
                        drn_d   = '0;
                    end
                end
            end
            ST_DRAIN: begin
                // Wait out the butterfly so the next pass never reads a bank
                // word whose write-back is still in flight.
                drn_d = drn_q + DRN_W'(1);
                if (drn_q == LAST_DRN) begin
                    cnt_d   = '0;
                    stage_d = stage_q + 4'd1;
                    state_d = (stage_q + 4'd1 == NSTG_4) ? ST_FIN : ST_RUN;
                end
            end
            ST_FIN: begin
                done    = 1'b1;
                stage_d = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy = (state_q == ST_RUN) || (state_q == ST_DRAIN);

    // Radix-4 pass s uses twiddle group cnt >> (ADDR_W-2s); once 2s reaches
    // ADDR_W every butterfly has its own twiddle. The radix-2 tail pass
    // indexes its block linearly.
    int tw_off;
    int tw_sh;
    int tw_sum;

    always_comb begin
        tw_off = tw_offset(int'(stage_q));
        tw_sh  = ADDR_W - 2 * int'(stage_q);
        if (tw_sh < 0) tw_sh = 0;
        if (int'(stage_q) < R4) tw_sum = tw_off + (int'(cnt_q) >> tw_sh);
        else                    tw_sum = tw_off + int'(cnt_q);
    end

    assign tw_addr_o = busy ? tw_sum[TW_W-1:0] : '0;
    assign sel_o     = busy && (int'(stage_q) < R4);
    assign ien_o     = ien;
    assign rd_addr_o = cnt_q;
    assign stage_o   = stage_q;
    assign busy_o    = busy;
    assign done_o    = done;

    ntt_wb_delay #(
        .DEPTH  (BF_LAT),
        .ADDR_W (ADDR_W)
    ) u_wb_delay (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .vld_i  (ien),
        .addr_i (cnt_q),
        .vld_o  (wb_en_o),
        .addr_o (wb_addr_o)
    );

`ifdef NTT_STAGE_CTRL_PERF_EN
    logic [15:0] perf_cyc_q;
    logic [15:0] perf_stl_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_cyc_q <= '0;
            perf_stl_q <= '0;
        end else if (state_q == ST_IDLE && start_i) begin
            perf_cyc_q <= '0;
            perf_stl_q <= '0;
        end else begin
            if (busy && perf_cyc_q != 16'hFFFF)
                perf_cyc_q <= perf_cyc_q + 16'd1;
            if (state_q == ST_RUN && hold_i && perf_stl_q != 16'hFFFF)
                perf_stl_q <= perf_stl_q + 16'd1;
        end
    end

    assign perf_cycles_o = perf_cyc_q;
    assign perf_stalls_o = perf_stl_q;
`endif

endmodule

// File: doc/ntt_stage_ctrl.md
Name: ntt_stage_ctrl

Overview:
- Control and address-generation stage directly upstream of the mixed-radix compact butterfly.
- Sequences an N-point NTT over ceil(N_LOG/2) passes: radix-4 passes, plus a final radix-2 pass when N_LOG is odd.
- Per issue cycle it drives the butterfly mode (sel), issue enable (ien), the common bank read address and the twiddle ROM address.
- Also produces the matching write-back address and enable, delayed by the butterfly latency, and drains the pipeline between passes to avoid read-after-write hazards.

Parameters:
- N_LOG, 8, log2 of transform length N; legal range 3..12.
- BF_LAT, 2, butterfly input-to-output latency in cycles; legal range >= 1.
- ADDR_W, N_LOG-2, bank address width (4 coefficient banks).
- TW_W, N_LOG, twiddle ROM address width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begin transform; sampled only in IDLE.
- hold  in  1  memory stall; freezes issue.
- sel  out  1  butterfly mode: 1 = radix-4, 0 = radix-2.
- ien  out  1  issue enable to butterfly.
- rd_addr  out  ADDR_W  bank read address.
- tw_addr  out  TW_W  twiddle ROM address.
- stage  out  4  current pass index.
- wb_en  out  1  write-back valid.
- wb_addr  out  ADDR_W  write-back address.
- busy  out  1  transform in progress.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - All outputs 0.
  - Counters and delay line cleared.
  - Applies mid-operation; the aborted transform emits no done.
- Derived constants:
  - R4 = N_LOG/2 (integer division); R2 = N_LOG%2.
  - NSTG = R4 + R2.
  - NCYC = N/4 = 2^ADDR_W issues per pass.
- FSM states: IDLE, RUN, DRAIN, FIN.
- IDLE:
  - start=1 goes to RUN; stage=0, cnt=0, busy=1 from the next cycle.
  - start while busy is ignored.
- RUN, each cycle with hold=0:
  - ien=1, rd_addr=cnt, cnt increments.
  - At cnt=NCYC-1 go to DRAIN.
- RUN with hold=1:
  - ien=0; cnt, rd_addr and tw_addr frozen.
  - No pass or state change.
- sel = 1 while stage < R4, else 0. It changes only at pass boundaries, never mid-pass.
- tw_addr, radix-4 pass s:
  - OFF(s) = (4^s-1)/3.
  - tw_addr = OFF(s) + (cnt >> (ADDR_W-2s)); for 2s >= ADDR_W the shift is 0.
- tw_addr, radix-2 pass: OFF(R4) + cnt.
- All tw arithmetic is unsigned, truncated to TW_W.
- Write-back delay line:
  - BF_LAT-deep shift register of {ien, rd_addr}; advances every cycle, regardless of hold.
  - wb_en and wb_addr are its outputs, so wb_en(t) = ien(t-BF_LAT).
- DRAIN:
  - Lasts exactly BF_LAT cycles; ien=0 and hold is ignored.
  - Then stage increments, cnt=0.
  - If the incremented stage equals NSTG, go to FIN; otherwise go to RUN.
- FIN:
  - done=1 for one cycle, busy=0.
  - Return to IDLE.
  - start asserted in FIN is ignored; it is accepted only in IDLE.
- Hold-free busy time = NSTG*(NCYC+BF_LAT) cycles. Each hold cycle during RUN adds one cycle.
- rd_addr wraps naturally at NCYC; it never exceeds NCYC-1.

Optional Feature:
- Macro: NTT_STAGE_CTRL_PERF_EN.
- With the macro defined:
  - Adds output perf_cycles [15:0] and perf_stalls [15:0].
  - perf_cycles counts busy cycles; perf_stalls counts RUN cycles with hold=1.
  - Both clear on accepted start and on reset, and hold their values in IDLE.
  - Both saturate at 16'hFFFF.
- Without the macro: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package ntt_pkg holds:
  - FSM state enum.
  - Function tw_offset(s) returning (4^s-1)/3.
  - Constants NSTG and NCYC as functions of N_LOG.
- One sub-module, ntt_wb_delay: parameterised BF_LAT-stage shift register carrying {valid, addr}, reset to 0.
- FSM and address generation stay in the top.

Test Plan:
- N_LOG=4, BF_LAT=2, start pulse at cycle 0, hold=0:
  - 2 radix-4 passes with sel=1 throughout.
  - ien high cycles 1-4 and 7-10; rd_addr 0,1,2,3 in each pass.
  - wb_en high cycles 3-6 and 9-12; done at cycle 13, busy high cycles 1-12.
- N_LOG=5, BF_LAT=2, hold=0:
  - 3 passes; sel=1,1,0.
  - Pass-2 tw_addr = 5+cnt, i.e. 5..12.
  - Busy for 30 cycles, then a single done pulse.
- N_LOG=4, hold=1 for cycles 2-3 of pass 0:
  - ien low and rd_addr held at 1 during the stall.
  - Pass completes with all addresses 0-3 issued once.
  - done delayed by exactly 2 cycles, to cycle 15.
- N_LOG=6, pass 1, cnt 0..15:
  - tw_addr = 1+(cnt>>2), giving values 1,1,1,1,2,...,4.
  - In pass 2 the shift is 0, giving tw_addr = 5+cnt.
- Reset asserted mid pass 1:
  - All outputs 0 asynchronously; no done pulse.
  - A fresh start then completes a normal transform.
- With NTT_STAGE_CTRL_PERF_EN, scenario 3:
  - perf_cycles=14, perf_stalls=2 after done.
  - Both values held until the next start.
